// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the CPU memory bus.
// A grant is held from the first request until the slave completes the transfer or the master aborts.
module mips_bus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  input  logic [3:0]        m0_byteenable,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  input  logic [3:0]        m1_byteenable,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [31:0]       s_writedata,
  output logic [3:0]        s_byteenable,
  input  logic              s_waitrequest,
  input  logic [31:0]       s_readdata,

  output logic [1:0]        grant,
  output logic [1:0]        dbg_state,
  output logic              dbg_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q;
  logic   last_q;
  logic   req0;
  logic   req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Handshake: a master holds read/write (and its address/data) until it sees
  // waitrequest low at a rising edge; that edge is the completion of the transfer.
  // Dropping the request earlier is an abort and returns the bus to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 && req1) state_q <= last_q ? GNT0 : GNT1;
          else if (req0)    state_q <= GNT0;
          else if (req1)    state_q <= GNT1;
        end
        GNT0: begin
          if (!req0) begin
            state_q <= IDLE;
          end else if (!s_waitrequest) begin
            last_q  <= 1'b0;
            state_q <= req1 ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (!req1) begin
            state_q <= IDLE;
          end else if (!s_waitrequest) begin
            last_q  <= 1'b1;
            state_q <= req0 ? GNT0 : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Slave-side mux: zeros and stalled masters whenever nobody owns the bus,
  // which also covers the asynchronous drop of strobes on reset.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      GNT0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      GNT1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  assign grant     = {state_q == GNT1, state_q == GNT0};
  assign dbg_state = state_q;
  assign dbg_last  = last_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: reset, single read, contention, stall, abort, mid-transfer reset.
module tb_mips_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic [1:0]  grant;
  logic [1:0]  dbg_state;
  logic        dbg_last;

  int vectors;
  int miscompares;

  mips_bus_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .dbg_state(dbg_state), .dbg_last(dbg_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    m0_address = 32'h0; m1_address = 32'h0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_writedata = 32'h0; m1_writedata = 32'h0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    s_waitrequest = 1'b0;
    s_readdata = 32'h0;

    // reset held with both masters requesting
    m0_address = 32'h0000_1000; m1_address = 32'h0000_2000;
    m0_read = 1; m1_read = 1;
    step(); step();
    chk("rst_s_read", {31'd0, s_read}, 32'd0);
    chk("rst_s_write", {31'd0, s_write}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    chk("rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    chk("rst_s_addr", s_address, 32'd0);
    chk("rst_last", {31'd0, dbg_last}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_rst_grant", {30'd0, grant}, 32'd1);
    chk("post_rst_addr", s_address, 32'h0000_1000);
    step();
    m0_read = 0;
    #1;
    chk("handover_grant", {30'd0, grant}, 32'd2);
    chk("handover_m1_wait", {31'd0, m1_waitrequest}, 32'd0);
    chk("handover_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    step();
    m1_read = 0;
    #1;
    chk("handover_idle", {30'd0, grant}, 32'd0);

    // single zero-wait read by m0
    step();
    m0_address = 32'hBFC0_0000; m0_read = 1; s_readdata = 32'h2402_000A;
    #1;
    chk("rd_wait_before", {31'd0, m0_waitrequest}, 32'd1);
    chk("rd_strobe_before", {31'd0, s_read}, 32'd0);
    step();
    chk("rd_grant", {30'd0, grant}, 32'd1);
    chk("rd_s_read", {31'd0, s_read}, 32'd1);
    chk("rd_s_addr", s_address, 32'hBFC0_0000);
    chk("rd_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
    chk("rd_data", m0_readdata, 32'h2402_000A);
    step();
    m0_read = 0;
    #1;
    chk("rd_done_grant", {30'd0, grant}, 32'd0);
    chk("rd_done_s_read", {31'd0, s_read}, 32'd0);
    chk("rd_last", {31'd0, dbg_last}, 32'd0);

    // contention: both masters write continuously
    pulse_reset();
    m0_writedata = 32'h1111_1111; m1_writedata = 32'h2222_2222;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_write = 1; m1_write = 1;
    step();
    chk("ct1_grant", {30'd0, grant}, 32'd1);
    chk("ct1_data", s_writedata, 32'h1111_1111);
    chk("ct1_write", {31'd0, s_write}, 32'd1);
    step();
    chk("ct2_grant", {30'd0, grant}, 32'd2);
    chk("ct2_data", s_writedata, 32'h2222_2222);
    step();
    chk("ct3_grant", {30'd0, grant}, 32'd1);
    chk("ct3_data", s_writedata, 32'h1111_1111);
    step();
    chk("ct4_grant", {30'd0, grant}, 32'd2);
    chk("ct4_data", s_writedata, 32'h2222_2222);
    m0_write = 0; m1_write = 0;
    step();
    chk("ct_abort_grant", {30'd0, grant}, 32'd0);
    chk("ct_abort_last", {31'd0, dbg_last}, 32'd0);

    // stall: m1 write held 3 cycles while m0 waits
    m1_address = 32'h0000_0040; m1_byteenable = 4'b0011; m1_write = 1;
    m0_address = 32'h0000_0080; m0_read = 1;
    s_waitrequest = 1;
    step();
    chk("st1_grant", {30'd0, grant}, 32'd2);
    chk("st1_be", {28'd0, s_byteenable}, 32'h3);
    chk("st1_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    chk("st1_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    step();
    chk("st2_grant", {30'd0, grant}, 32'd2);
    chk("st2_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    step();
    chk("st3_grant", {30'd0, grant}, 32'd2);
    s_waitrequest = 0;
    #1;
    chk("st3_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    chk("st3_m1_wait", {31'd0, m1_waitrequest}, 32'd0);
    step();
    m1_write = 0;
    #1;
    chk("st_sw_grant", {30'd0, grant}, 32'd1);
    chk("st_sw_addr", s_address, 32'h0000_0080);
    chk("st_sw_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
    step();
    m0_read = 0;
    #1;
    chk("st_end_grant", {30'd0, grant}, 32'd0);

    // m1 single write sets last to 1
    m1_write = 1;
    step();
    chk("w1_grant", {30'd0, grant}, 32'd2);
    step();
    m1_write = 0;
    #1;
    chk("w1_last", {31'd0, dbg_last}, 32'd1);

    // abort: m0 drops its read while stalled
    m0_read = 1; s_waitrequest = 1;
    step();
    chk("ab_grant", {30'd0, grant}, 32'd1);
    step();
    chk("ab_stalled", {30'd0, grant}, 32'd1);
    m0_read = 0;
    step();
    chk("ab_idle", {30'd0, grant}, 32'd0);
    chk("ab_last", {31'd0, dbg_last}, 32'd1);

    // tie after abort goes to m0, then handover into a stalled m1 read
    m0_read = 1; m1_read = 1; m1_address = 32'h0000_0100;
    step();
    chk("tie_grant", {30'd0, grant}, 32'd1);
    s_waitrequest = 0;
    step();
    m0_read = 0; s_waitrequest = 1;
    #1;
    chk("mr_grant", {30'd0, grant}, 32'd2);
    chk("mr_s_read", {31'd0, s_read}, 32'd1);
    step();

    // asynchronous reset mid-transfer
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_s_read", {31'd0, s_read}, 32'd0);
    chk("ar_grant", {30'd0, grant}, 32'd0);
    chk("ar_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    chk("ar_last", {31'd0, dbg_last}, 32'd1);
    m0_read = 1;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ar_rel_grant", {30'd0, grant}, 32'd1);
    m0_read = 0; m1_read = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master, one-slave arbiter for the CPU memory bus. It shares the single bus memory between the CPU bus master (master 0) and a second master such as a loader or DMA engine (master 1). Arbitration is round-robin at transaction granularity, and a grant is held until the slave completes the transfer. It sits between the masters and the memory instance in the top-level and testbench, using the same read/write/waitrequest/byteenable handshake on every port.

## Interface

- ADDR_W, 32, address width on all ports.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- m0_address, m1_address  in  ADDR_W  master byte address.
- m0_read, m1_read  in  1  read request.
- m0_write, m1_write  in  1  write request.
- m0_writedata, m1_writedata  in  32  write data.
- m0_byteenable, m1_byteenable  in  4  byte lanes.
- m0_waitrequest, m1_waitrequest  out  1  stall to master.
- m0_readdata, m1_readdata  out  32  read data to master.
- s_address  out  ADDR_W  address to memory.
- s_read  out  1  read strobe to memory.
- s_write  out  1  write strobe to memory.
- s_writedata  out  32  write data to memory.
- s_byteenable  out  4  byte lanes to memory.
- s_waitrequest  in  1  memory stall.
- s_readdata  in  32  memory read data.
- grant  out  2  one-hot current owner: bit0 = master 0, bit1 = master 1; 00 when idle.

## Operation

- Master x requests when `mx_read | mx_write` is set. A master asserting both read and write is a protocol error; the arbiter forwards both unchanged.
- The state machine has three states: IDLE, GNT0 and GNT1. A `last` register records the master most recently granted; its reset value is 1, so master 0 wins the first tie.
- From IDLE:
  - If only one master requests, go to GNTx for that master.
  - If both request, grant the master that is not `last`.
  - If neither requests, stay in IDLE.
- In GNTx:
  - Master x's address, read, write, writedata and byteenable are forwarded combinationally to `s_*`.
  - `mx_waitrequest = s_waitrequest`.
  - The other master's waitrequest is 1.
- Completion is an edge in GNTx where `(mx_read|mx_write) & !s_waitrequest`. On completion, `last <= x`.
  - If the other master is requesting, go directly to GNTother.
  - Otherwise go to IDLE.
- If master x drops its request in GNTx before completion (abort), go to IDLE at the next edge and leave `last` unchanged.
- In IDLE:
  - `s_read = s_write = 0`.
  - `s_address`, `s_writedata` and `s_byteenable` are 0.
  - Both master waitrequests are 1.
- `m0_readdata` and `m1_readdata` both carry `s_readdata` unmodified. It is valid only for the granted master, in the cycle its waitrequest is low.
- `grant` is decoded from the state register.

## Timing

- Reset (rst = 0, async) forces:
  - state = IDLE, last = 1, grant = 00;
  - s_read = s_write = 0, all `s_*` data and address outputs = 0;
  - m0_waitrequest = m1_waitrequest = 1.
- Arbitration latency is one cycle. A request first sampled at edge N in IDLE puts the slave strobe on the bus in cycle N+1.
- With a zero-wait memory, an isolated transfer completes at edge N+1. The master sees waitrequest = 1 in cycle N and 0 in cycle N+1.
- Handover between masters has no bubble. When the other master is waiting, its strobe appears in the cycle right after completion.
- A single master issuing back-to-back transfers gets one IDLE cycle between them, i.e. 2 cycles per transfer with a zero-wait memory.
- A memory stall of k cycles holds the grant for k extra cycles. The other master stays stalled throughout.
- A request arriving in the same cycle as a completion is treated as already pending for handover.
- Reset mid-transfer:
  - Strobes drop immediately (asynchronous); there is no completion.
  - After reset is released, arbitration restarts from IDLE with last = 1.

## Test plan

- Reset: hold rst = 0 with both masters requesting -> s_read = s_write = 0, grant = 00, both waitrequests = 1. Release -> grant = 01 one edge later.
- Single read: m0 reads 0xBFC00000 from a zero-wait memory holding 0x2402000A -> s_read high for exactly 1 cycle, m0_waitrequest low that cycle, m0_readdata = 0x2402000A, grant returns to 00.
- Contention: m0 and m1 both write continuously (m0 data 0x11111111, m1 data 0x22222222) -> grant sequence 01, 10, 01, 10 with no idle gap, and memory writes alternate 0x11111111, 0x22222222.
- Stall: m1 write with memory waitrequest held for 3 cycles while m0 requests -> m0_waitrequest stays 1 throughout. Grant switches to m0 on the edge after m1 completes, and byteenable 0b0011 reaches s_byteenable unchanged.
- Abort: m0 drops read after 1 stalled cycle -> state goes to IDLE, last is unchanged, and the next m0/m1 tie still grants m1 only if last = 0.
- Mid-transfer reset: assert rst low during a stalled m1 read -> s_read drops in the same cycle. After release, a simultaneous request grants m0 first.
